// File: rtl/bitser_add_pkg.sv
// Shared types and constants for the bit-serial add scheduler.
package bitser_add_pkg;

  // Number of requesters competing for the shared adder cell.
  localparam int NUM_REQ = 2;

  // Identifies which requester owns an operation.
  typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

  // Scheduler states: waiting for a request, adding bits, and holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bitser_fa.sv
// Combinational 1-bit full adder: the single arithmetic cell shared by all requesters.
module bitser_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);

  // Sum is the parity of the inputs; carry is their majority.
  always_comb begin
    sum  = a ^ b ^ c;
    cout = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/bitser_add_arb.sv
// Bit-serial add scheduler: round-robin arbitration between two requesters for one
// shared full-adder cell. Operands are added LSB-first over WIDTH cycles with the carry
// kept in a flop, and the result is returned on a valid/ready port tagged with the owner.
// Optional feature: define BITSER_ADD_ARB_OVF_EN to add the rsp_ovf signed-overflow output.
module bitser_add_arb
  import bitser_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
`ifdef BITSER_ADD_ARB_OVF_EN
  ,
  output logic             rsp_ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_id_t          id_q, id_d;
  req_id_t          last_grant_q, last_grant_d;
`ifdef BITSER_ADD_ARB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  req_id_t          grant_id;
  logic             grant_any;
  logic [WIDTH-1:0] bit_mask;
  logic             a_bit, b_bit;
  logic             fa_sum, fa_cout;

  // Round-robin pick: when both ask, the requester not served last wins.
  always_comb begin
    grant_id  = '0;
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign req0_ready = (state_q == IDLE) && grant_any && (grant_id == 1'b0);
  assign req1_ready = (state_q == IDLE) && grant_any && (grant_id == 1'b1);

  // Select the operand bits addressed by the counter; a one-hot mask avoids
  // indexing with a counter that is wider than the bit-position range.
  always_comb begin
    bit_mask = WIDTH'(1'b1) << cnt_q;
    a_bit    = |(a_q & bit_mask);
    b_bit    = |(b_q & bit_mask);
  end

  bitser_fa u_fa (
    .a    (a_bit),
    .b    (b_bit),
    .c    (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state logic: accept in IDLE, one bit per cycle in RUN, hold in DONE.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
`ifdef BITSER_ADD_ARB_OVF_EN
    ovf_d        = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          if (grant_id == 1'b1) begin
            a_d     = req1_a;
            b_d     = req1_b;
            carry_d = req1_cin;
          end else begin
            a_d     = req0_a;
            b_d     = req0_b;
            carry_d = req0_cin;
          end
          res_d        = '0;
          cnt_d        = '0;
          id_d         = grant_id;
          last_grant_d = grant_id;
`ifdef BITSER_ADD_ARB_OVF_EN
          ovf_d        = 1'b0;
`endif
          state_d      = RUN;
        end
      end
      RUN: begin
        res_d   = fa_sum ? (res_q | bit_mask) : (res_q & ~bit_mask);
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef BITSER_ADD_ARB_OVF_EN
          ovf_d = carry_q ^ fa_cout;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any operation and favours req0 next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
      id_q         <= '0;
      last_grant_q <= 1'b1;
`ifdef BITSER_ADD_ARB_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      carry_q      <= carry_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
`ifdef BITSER_ADD_ARB_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = res_q;
  assign rsp_cout  = carry_q;
  assign rsp_id    = id_q;
`ifdef BITSER_ADD_ARB_OVF_EN
  assign rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_bitser_add_arb.sv
// Self-checking bench for bitser_add_arb: a monitor keeps an abstract model of the
// scheduler (busy flag, cycles since accept, round-robin winner) and a queue of expected
// results computed with plain arithmetic; directed and random stimulus drive the DUT.
module tb_bitser_add_arb;

  localparam int WIDTH  = 8;
  localparam int BUDGET = 4 * WIDTH + 40;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             id;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             req0_valid, req0_ready, req0_cin;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_cin;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [WIDTH-1:0] rsp_sum;
`ifdef BITSER_ADD_ARB_OVF_EN
  logic             rsp_ovf;
`endif

  int   assertions = 0;
  int   failures   = 0;
  int   cycle      = 0;
  logic sat_mode   = 1'b0;
  exp_t exp_q[$];

  bitser_add_arb #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
`ifdef BITSER_ADD_ARB_OVF_EN
    ,
    .rsp_ovf    (rsp_ovf)
`endif
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if something hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it, and report actual versus required on a miss.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    assertions++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Reference result of a+b+cin as unsigned and two's-complement arithmetic.
  function automatic exp_t refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic cin, input logic id);
    exp_t        e;
    logic [WIDTH:0] full;
    full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.id   = id;
    e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // Operand generator biased towards the all-zero and all-one corners.
  function automatic logic [WIDTH-1:0] randOperand();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = '0;
      1:       v = '1;
      default: v = WIDTH'($urandom());
    endcase
    return v;
  endfunction

  // Drive both request ports.
  task automatic applyStimulus(input logic v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                               input logic c0, input logic v1, input logic [WIDTH-1:0] a1,
                               input logic [WIDTH-1:0] b1, input logic c1);
    req0_valid = v0;
    req0_a     = a0;
    req0_b     = b0;
    req0_cin   = c0;
    req1_valid = v1;
    req1_a     = a1;
    req1_b     = b1;
    req1_cin   = c1;
  endtask

  // Hold the current request until an accept is visible before the coming edge.
  task automatic waitAccept();
    bit got;
    got = 1'b0;
    for (int i = 0; i < BUDGET && !got; i++) begin
      #3;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      assertions++;
      failures++;
      $display("[TB] FAIL accept_timeout: got no accept required accept within %0d cycles", BUDGET);
    end
  endtask

  // Wait for a response and compare it against directed constants.
  task automatic waitRsp(input string name, input logic [WIDTH-1:0] s, input logic c, input logic id);
    bit got;
    got = 1'b0;
    for (int i = 0; i < BUDGET && !got; i++) begin
      @(negedge clk);
      #3;
      if (rsp_valid) got = 1'b1;
    end
    if (!got) begin
      assertions++;
      failures++;
      $display("[TB] FAIL %s_timeout: got no rsp_valid required rsp_valid within %0d cycles", name, BUDGET);
    end else begin
      checkOutput({name, "_sum"}, 64'(rsp_sum), 64'(s));
      checkOutput({name, "_cout"}, 64'(rsp_cout), 64'(c));
      checkOutput({name, "_id"}, 64'(rsp_id), 64'(id));
    end
  endtask

  // Monitor/scoreboard: predicts readiness, response timing and response contents.
  initial begin : monitor
    bit         busy;
    int         since;
    bit         last_was_req1;
    bit         have_prev;
    int         prev_acc;
    logic [1:0] exp_rdy;
    logic       exp_rv, any_v, win, was_busy;
    exp_t       e;
    busy          = 1'b0;
    since         = 0;
    last_was_req1 = 1'b1;
    have_prev     = 1'b0;
    prev_acc      = 0;
    forever begin
      @(negedge clk);
      #2;
      cycle++;
      if (reset) begin
        checkOutput("reset_outputs",
                    64'({rsp_valid, rsp_sum, rsp_cout, rsp_id, req0_ready, req1_ready}), 64'(0));
`ifdef BITSER_ADD_ARB_OVF_EN
        checkOutput("reset_ovf", 64'(rsp_ovf), 64'(0));
`endif
        exp_q.delete();
        busy          = 1'b0;
        since         = 0;
        last_was_req1 = 1'b1;
        have_prev     = 1'b0;
      end else begin
        if (busy) since++;
        was_busy = busy;
        any_v    = req0_valid | req1_valid;
        win      = (req0_valid && req1_valid) ? !last_was_req1 : req1_valid;
        exp_rdy  = (!busy && any_v) ? (win ? 2'b10 : 2'b01) : 2'b00;
        checkOutput("req_ready", 64'({req1_ready, req0_ready}), 64'(exp_rdy));
        exp_rv = busy && (since >= WIDTH);
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
          e = exp_q[0];
          checkOutput("rsp_sum", 64'(rsp_sum), 64'(e.sum));
          checkOutput("rsp_cout", 64'(rsp_cout), 64'(e.cout));
          checkOutput("rsp_id", 64'(rsp_id), 64'(e.id));
`ifdef BITSER_ADD_ARB_OVF_EN
          checkOutput("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
`endif
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            busy = 1'b0;
          end
        end
        if (!sat_mode) have_prev = 1'b0;
        if (!was_busy && any_v) begin
          if (win) exp_q.push_back(refModel(req1_a, req1_b, req1_cin, 1'b1));
          else     exp_q.push_back(refModel(req0_a, req0_b, req0_cin, 1'b0));
          last_was_req1 = win;
          busy          = 1'b1;
          since         = -1;
          if (sat_mode) begin
            if (have_prev) checkOutput("accept_spacing", 64'(cycle - prev_acc), 64'(WIDTH + 2));
            prev_acc  = cycle;
            have_prev = 1'b1;
          end
        end
      end
    end
  end

  // Stimulus sequence: directed cases from the plan, then randomized traffic.
  initial begin : stimulus
    reset     = 1'b1;
    rsp_ready = 1'b1;
    applyStimulus(0, '0, '0, 0, 0, '0, '0, 0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed add, requester 0");
    applyStimulus(1, 8'h5A, 8'h3C, 0, 0, '0, '0, 0);
    waitAccept();
    @(negedge clk);
    applyStimulus(0, 8'hFF, 8'hFF, 1, 0, '0, '0, 0);
    waitRsp("req0_5a_3c", 8'h96, 1'b0, 1'b0);

    $display("[TB] directed add, requester 1 with carry-in");
    @(negedge clk);
    applyStimulus(0, '0, '0, 0, 1, 8'hFF, 8'h01, 1);
    waitAccept();
    @(negedge clk);
    applyStimulus(0, '0, '0, 0, 0, '0, '0, 0);
    waitRsp("req1_ff_01", 8'h01, 1'b1, 1'b1);
`ifdef BITSER_ADD_ARB_OVF_EN
    checkOutput("req1_ff_01_ovf", 64'(rsp_ovf), 64'(0));
    @(negedge clk);
    applyStimulus(1, 8'h7F, 8'h01, 0, 0, '0, '0, 0);
    waitAccept();
    @(negedge clk);
    applyStimulus(0, '0, '0, 0, 0, '0, '0, 0);
    waitRsp("ovf_7f_01", 8'h80, 1'b0, 1'b0);
    checkOutput("ovf_7f_01_ovf", 64'(rsp_ovf), 64'(1));
`endif

    $display("[TB] saturated traffic from both requesters");
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      sat_mode = 1'b1;
      applyStimulus(1, randOperand(), randOperand(), 1'($urandom()),
                    1, randOperand(), randOperand(), 1'($urandom()));
    end
    @(negedge clk);
    sat_mode = 1'b0;
    applyStimulus(0, '0, '0, 0, 0, '0, '0, 0);
    repeat (WIDTH + 4) @(negedge clk);

    $display("[TB] response stall with requests pending");
    rsp_ready = 1'b0;
    applyStimulus(1, 8'hC3, 8'h5D, 1, 1, 8'h12, 8'h34, 0);
    waitAccept();
    repeat (WIDTH + 22) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    applyStimulus(0, '0, '0, 0, 0, '0, '0, 0);
    repeat (WIDTH + 4) @(negedge clk);

    $display("[TB] reset in the middle of an operation");
    applyStimulus(1, 8'h11, 8'h22, 0, 0, '0, '0, 0);
    waitAccept();
    @(negedge clk);
    applyStimulus(0, '0, '0, 0, 0, '0, '0, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midrun_reset_zero",
                64'({rsp_valid, rsp_sum, rsp_cout, rsp_id, req0_ready, req1_ready}), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 8'h0F, 8'hF0, 1, 1, 8'hAA, 8'h55, 1);
    #3;
    checkOutput("post_reset_grant", 64'({req1_ready, req0_ready}), 64'(2'b01));
    @(negedge clk);
    applyStimulus(0, '0, '0, 0, 0, '0, '0, 0);
    repeat (WIDTH + 4) @(negedge clk);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rsp_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(1'($urandom()), randOperand(), randOperand(), 1'($urandom()),
                    1'($urandom()), randOperand(), randOperand(), 1'($urandom()));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    applyStimulus(0, '0, '0, 0, 0, '0, '0, 0);
    repeat (WIDTH + 6) @(negedge clk);
    #3;
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/bitser_add_arb.md
# bitser_add_arb

Bit-serial add scheduler: arbitrates between two requesters for one shared 1-bit full-adder cell. Each granted operation is sequenced LSB-first over WIDTH cycles, with the carry held in a flop between bits. The result is returned through a valid/ready response port tagged with the requester id. It sits between operand producers and the adder cell, trading area for WIDTH+2-cycle throughput.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..64.

- clk  in  1  single clock; all flops rise-edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  operation accepted on this edge when high with req0_valid.
- req0_a, req0_b  in  WIDTH  requester 0 operands, unsigned.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_sum  out  WIDTH  a+b+cin modulo 2^WIDTH.
- rsp_cout  out  1  carry out of bit WIDTH-1.
- rsp_id  out  1  requester that owns the result.

## Operation
- FSM states IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - Grant is round-robin.
  - If both requesters are valid, the one not granted last wins. After reset, req0 has priority.
  - Only the granted requester sees ready=1. Both readies are 0 outside IDLE.
  - On accept: latch a, b, id; carry flop ← cin; bit counter ← 0; last_grant ← id; go to RUN.
- RUN, one bit per cycle:
  - Cell inputs are a[cnt], b[cnt], carry.
  - sum bit is written to result[cnt]; carry ← cell cout; cnt ← cnt+1.
  - When cnt==WIDTH-1, go to DONE.
- DONE:
  - rsp_valid=1; rsp_sum, rsp_cout, rsp_id held stable.
  - On rsp_valid&rsp_ready, go to IDLE. There is no bypass to RUN.
- Request inputs are sampled only on the accept edge. Later changes to them are ignored.
- Reset at any time, including mid-RUN or DONE:
  - The operation is dropped with no response.
  - Outputs: req*_ready=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0.
  - last_grant returns to favour req0.
- A requester whose valid drops before grant is not arbitrated. No state is kept for it.

## Timing
- Accept on edge t. Bits are computed on edges t+1..t+WIDTH. rsp_valid is high from the cycle after edge t+WIDTH.
- Latency from accept to first rsp_valid cycle is WIDTH cycles.
- Minimum spacing between accepts is WIDTH+2 cycles when rsp_ready is held at 1.
- WIDTH=1: a single RUN cycle, then DONE.
- rsp_ready held low stalls DONE indefinitely. The outputs must not change while stalled.
- Ready is a combinational function of state, last_grant and the valids. There is no path from rsp_ready to req*_ready in the same cycle.

## Configuration
- BITSER_ADD_ARB_OVF_EN defined:
  - Adds output rsp_ovf (1 bit): signed overflow = carry into bit WIDTH-1 XOR rsp_cout.
  - rsp_ovf is captured in the cycle that computes bit WIDTH-1.
  - Reset value 0. It obeys the same hold rules as the other rsp_* outputs.
- Undefined: the port and its flop are absent. All other behaviour is identical.

## Structure
- Shared package bitser_add_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the requester-id type;
  - the constant for the number of requesters (2).
- One sub-module, bitser_fa: the combinational 1-bit full adder.
  - sum = a^b^c.
  - cout = majority(a,b,c).
  - It is instantiated once and is the only arithmetic in the block.
- Counter width is $clog2(WIDTH+1).

## Test plan
- WIDTH=8, req0 a=0x5A b=0x3C cin=0 → after 8 cycles: rsp_sum=0x96, rsp_cout=0, rsp_id=0.
- req1 a=0xFF b=0x01 cin=1 → rsp_sum=0x01, rsp_cout=1, rsp_id=1. With OVF_EN: rsp_ovf=0.
- Both valid every cycle from reset, rsp_ready=1 → grants alternate 0,1,0,1. Accepts are spaced exactly 10 cycles apart.
- Hold rsp_ready=0 for 20 cycles in DONE → rsp_* are stable, both req ready=0, no new accept. Then rsp_ready=1 → IDLE on the next edge.
- Assert reset during RUN cnt=4 → all outputs are 0 immediately. After release, no response for the dropped operation. With both valid, req0 is granted first.
- With OVF_EN: a=0x7F b=0x01 cin=0 → rsp_sum=0x80, rsp_cout=0, rsp_ovf=1.
